result_stream_fifo: RTL



---
 rtl/result_fifo_pkg.sv | 19 +
 rtl/result_fifo_mem.sv | 25 ++
 rtl/result_stream_fifo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/result_fifo_pkg.sv
// Shared defaults, address-width helper and output-stage state encoding for the
// result stream FIFO.
package result_fifo_pkg;

   localparam int DATA_WIDTH_D   = 64;
   localparam int DEPTH_D        = 128;
   localparam int AFULL_THRESH_D = 80;
   localparam int PIPE_LAT_D     = 40;

   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_VALID = 1'b1
   } out_state_t;

endpackage

// File: rtl/result_fifo_mem.sv
// Simple dual-port RAM holding {tlast, tdata}; synchronous write and
// synchronous (registered) read.
module result_fifo_mem
   import result_fifo_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH_D + 1,
   parameter int DEPTH = DEPTH_D
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [addr_width(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        rd_en,
   input  logic [addr_width(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]            rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/result_stream_fifo.sv
// No-backpressure result beats in, AXI4-Stream out, with almost-full throttle and
// overflow tracking. Define RESULT_FIFO_STATS_EN to build the beat/drop counters.
module result_stream_fifo
   import result_fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_D,
   parameter int DEPTH        = DEPTH_D,
   parameter int AFULL_THRESH = AFULL_THRESH_D
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [DATA_WIDTH-1:0]      s_tdata,
   input  logic                       s_tvalid,
   input  logic                       s_tlast,
   output logic [DATA_WIDTH-1:0]      m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic                       m_tlast,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       clear_overflow,
   output logic [31:0]                beat_count,
   output logic [31:0]                drop_count
);

   localparam int AW = addr_width(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int EW = DATA_WIDTH + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] ONE_L   = LW'(1);

   out_state_t    state;
   logic          pf_vld, rd_pend;
   logic [EW-1:0] pf_entry, rd_entry, s_entry, out_entry;
   logic [LW-1:0] ram_cnt, ram_cnt_n, level_n;
   logic [AW-1:0] wptr, rptr;
   logic          pop, wr_ok, drop, out_load;
   logic          take_pf, take_rd, bypass, rd_to_pf, wr_pf, wr_ram, rd_issue;
   logic          out_vld_n, pf_vld_n, load_out;

   assign m_tvalid = (state == ST_VALID);
   assign s_entry  = {s_tlast, s_tdata};
   assign pop      = m_tvalid && m_tready;
   assign wr_ok    = s_tvalid && ((level != DEPTH_L) || pop);
   assign drop     = s_tvalid && !wr_ok;
   assign out_load = !m_tvalid || m_tready;

   // Route each entry to the oldest free slot: output register, then prefetch, then RAM.
   // A read is only launched when a slot is guaranteed for its data next cycle.
   always_comb begin
      take_pf   = 1'b0;
      take_rd   = 1'b0;
      bypass    = 1'b0;
      rd_to_pf  = 1'b0;
      wr_pf     = 1'b0;
      wr_ram    = 1'b0;
      out_vld_n = m_tvalid && !m_tready;
      pf_vld_n  = pf_vld;
      if (out_load) begin
         if (pf_vld) begin
            take_pf   = 1'b1;
            pf_vld_n  = 1'b0;
            out_vld_n = 1'b1;
         end else if (rd_pend) begin
            take_rd   = 1'b1;
            out_vld_n = 1'b1;
         end else if (wr_ok && ram_cnt == '0) begin
            bypass    = 1'b1;
            out_vld_n = 1'b1;
         end
      end
      if (rd_pend && !take_rd) begin
         rd_to_pf = 1'b1;
         pf_vld_n = 1'b1;
      end
      if (wr_ok && !bypass) begin
         if (ram_cnt == '0 && !pf_vld_n) begin
            wr_pf    = 1'b1;
            pf_vld_n = 1'b1;
         end else begin
            wr_ram = 1'b1;
         end
      end
      rd_issue = (ram_cnt != '0) && !(out_vld_n && pf_vld_n);
   end

   assign load_out  = take_pf || take_rd || bypass;
   assign out_entry = take_pf ? pf_entry : (take_rd ? rd_entry : s_entry);

   always_comb begin
      ram_cnt_n = ram_cnt;
      if (wr_ram && !rd_issue) ram_cnt_n = ram_cnt + ONE_L;
      if (!wr_ram && rd_issue) ram_cnt_n = ram_cnt - ONE_L;
      level_n = level;
      if (wr_ok && !pop) level_n = level + ONE_L;
      if (!wr_ok && pop) level_n = level - ONE_L;
   end

   result_fifo_mem #(.WIDTH(EW), .DEPTH(DEPTH)) u_mem (
      .clk     (aclk),
      .wr_en   (wr_ram),
      .wr_addr (wptr),
      .wr_data (s_entry),
      .rd_en   (rd_issue),
      .rd_addr (rptr),
      .rd_data (rd_entry)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= ST_EMPTY;
         m_tdata <= '0;
         m_tlast <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: if (load_out) begin
               state              <= ST_VALID;
               {m_tlast, m_tdata} <= out_entry;
            end
            ST_VALID: if (pop) begin
               if (load_out) {m_tlast, m_tdata} <= out_entry;
               else          state              <= ST_EMPTY;
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pf_vld      <= 1'b0;
         rd_pend     <= 1'b0;
         ram_cnt     <= '0;
         wptr        <= '0;
         rptr        <= '0;
         level       <= '0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         pf_vld      <= pf_vld_n;
         rd_pend     <= rd_issue;
         ram_cnt     <= ram_cnt_n;
         level       <= level_n;
         almost_full <= (level_n >= AFULL_L);
         if (wr_ram)   wptr <= wptr + AW'(1);
         if (rd_issue) rptr <= rptr + AW'(1);
         if (drop)                overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (rd_to_pf)   pf_entry <= rd_entry;
      else if (wr_pf) pf_entry <= s_entry;
   end

`ifdef RESULT_FIFO_STATS_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         beat_count <= '0;
         drop_count <= '0;
      end else begin
         if (pop  && beat_count != 32'hFFFF_FFFF) beat_count <= beat_count + 32'd1;
         if (drop && drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
      end
   end
`else
   assign beat_count = '0;
   assign drop_count = '0;
`endif

endmodule
